// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions, wakes sources from the CDB,
// and issues the oldest fully ready entry to its functional unit.
package rs_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 4;

    typedef struct packed {
        logic [1:0]             fu;
        logic [3:0]             func;
        logic [2:0]             func3;
        logic [ROB_TAG_LEN-1:0] tag_dest;
        logic [ROB_TAG_LEN-1:0] tag_src1;
        logic [ROB_TAG_LEN-1:0] tag_src2;
        logic                   ready_src1;
        logic                   ready_src2;
        logic [XLEN-1:0]        value_src1;
        logic [XLEN-1:0]        value_src2;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        npc;
        logic [7:0]             insn_tag;
    } inst_rs_t;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int RS_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  inst_rs_t               inst_rs,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    input  logic                   squash,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output inst_rs_t               issue_inst,
    output logic                   is_full
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CW = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [IW-1:0]      rank_q  [RS_SIZE];
    logic [IW-1:0]      rank_d  [RS_SIZE];
    inst_rs_t           entry_q [RS_SIZE];
    inst_rs_t           entry_d [RS_SIZE];

    logic [RS_SIZE-1:0] rdy;
    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      sel_rank;
    logic               free_found;
    logic [IW-1:0]      free_idx;
    logic [CW-1:0]      vcount;
    logic [CW-1:0]      surv;
    logic               do_issue;
    logic               do_load;
    inst_rs_t           cap;

    assign is_full = &valid_q;

    // Ranks of valid entries are unique, so the minimum rank identifies the oldest ready entry.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            rdy[i] = valid_q[i] & entry_q[i].ready_src1 & entry_q[i].ready_src2;
            if (rdy[i] && (!sel_found || rank_q[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_rank  = rank_q[i];
            end
        end
    end

    assign issue_valid = !squash && sel_found;
    assign issue_inst  = issue_valid ? entry_q[sel_idx] : '0;
    assign do_issue    = issue_valid && issue_ready;
    assign do_load     = load && !squash && !is_full;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        vcount     = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            vcount = vcount + CW'(valid_q[i]);
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        surv = vcount - CW'(do_issue);
    end

    // A source broadcast in the same cycle as dispatch is captured on the way in.
    always_comb begin
        cap = inst_rs;
        if (cdb_valid && !inst_rs.ready_src1 && inst_rs.tag_src1 == cdb_tag) begin
            cap.ready_src1 = 1'b1;
            cap.value_src1 = cdb_value;
        end
        if (cdb_valid && !inst_rs.ready_src2 && inst_rs.tag_src2 == cdb_tag) begin
            cap.ready_src2 = 1'b1;
            cap.value_src2 = cdb_value;
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            rank_d[i]  = rank_q[i];
            entry_d[i] = entry_q[i];
        end
        if (squash) begin
            valid_d = '0;
            for (int i = 0; i < RS_SIZE; i++) rank_d[i] = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && cdb_valid) begin
                    if (!entry_q[i].ready_src1 && entry_q[i].tag_src1 == cdb_tag) begin
                        entry_d[i].ready_src1 = 1'b1;
                        entry_d[i].value_src1 = cdb_value;
                    end
                    if (!entry_q[i].ready_src2 && entry_q[i].tag_src2 == cdb_tag) begin
                        entry_d[i].ready_src2 = 1'b1;
                        entry_d[i].value_src2 = cdb_value;
                    end
                end
                if (do_issue && IW'(i) == sel_idx) begin
                    valid_d[i] = 1'b0;
                end else if (do_issue && valid_q[i] && rank_q[i] > sel_rank) begin
                    rank_d[i] = rank_q[i] - 1'b1;
                end
                if (do_load && IW'(i) == free_idx) begin
                    valid_d[i] = 1'b1;
                    rank_d[i]  = IW'(surv);
                    entry_d[i] = cap;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                rank_q[i]  <= '0;
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                rank_q[i]  <= rank_d[i];
                entry_q[i] <= entry_d[i];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
    import rs_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   load;
    inst_rs_t               inst_rs;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   squash;
    logic                   issue_ready;
    logic                   issue_valid;
    inst_rs_t               issue_inst;
    logic                   is_full;

    int n_chk  = 0;
    int n_fail = 0;

    reservation_station #(.RS_SIZE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .inst_rs    (inst_rs),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .squash     (squash),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_inst (issue_inst),
        .is_full    (is_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic inst_rs_t mk(input logic [7:0] itag,
                                    input logic [3:0] t1, input logic r1, input logic [31:0] v1,
                                    input logic [3:0] t2, input logic r2, input logic [31:0] v2);
        inst_rs_t p;
        p            = '0;
        p.fu         = 2'd1;
        p.tag_dest   = itag[3:0];
        p.tag_src1   = t1;
        p.ready_src1 = r1;
        p.value_src1 = v1;
        p.tag_src2   = t2;
        p.ready_src2 = r2;
        p.value_src2 = v2;
        p.pc         = {22'h0, itag, 2'b00};
        p.npc        = {22'h0, itag, 2'b00} + 32'd4;
        p.insn_tag   = itag;
        return p;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; load = 1'b0; inst_rs = '0; cdb_valid = 1'b0; cdb_tag = '0;
        cdb_value = '0; squash = 1'b0; issue_ready = 1'b0;
        #12;
        check_eq("rst_issue_valid", issue_valid, 1'b0);
        check_eq("rst_is_full", is_full, 1'b0);
        check_eq("rst_issue_inst", issue_inst, '0);
        tick();
        reset = 1'b1;

        // Both sources ready: issuable the cycle after dispatch, freed on the next edge.
        issue_ready = 1'b1;
        load = 1'b1; inst_rs = mk(8'h10, 4'd1, 1'b1, 32'd5, 4'd2, 1'b1, 32'd7);
        #1 check_eq("alu_pre_issue", issue_valid, 1'b0);
        tick(); load = 1'b0;
        #1 check_eq("alu_valid", issue_valid, 1'b1);
        check_eq("alu_v1", issue_inst.value_src1, 32'd5);
        check_eq("alu_v2", issue_inst.value_src2, 32'd7);
        tick();
        #1 check_eq("alu_freed", issue_valid, 1'b0);

        // Wakeup of src1 by a later broadcast, no same-cycle bypass.
        load = 1'b1; inst_rs = mk(8'h20, 4'd3, 1'b0, 32'd0, 4'd1, 1'b1, 32'd1);
        tick(); load = 1'b0;
        #1 check_eq("wake_wait", issue_valid, 1'b0);
        tick();
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h2A;
        #1 check_eq("wake_no_bypass", issue_valid, 1'b0);
        tick(); cdb_valid = 1'b0;
        #1 check_eq("wake_valid", issue_valid, 1'b1);
        check_eq("wake_v1", issue_inst.value_src1, 32'h2A);
        check_eq("wake_r1", issue_inst.ready_src1, 1'b1);
        tick();

        // Dispatch-time capture of src2.
        load = 1'b1; inst_rs = mk(8'h30, 4'd1, 1'b1, 32'd3, 4'd6, 1'b0, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'd9;
        tick(); load = 1'b0; cdb_valid = 1'b0;
        #1 check_eq("cap_valid", issue_valid, 1'b1);
        check_eq("cap_v2", issue_inst.value_src2, 32'd9);
        tick();
        #1 check_eq("cap_freed", issue_valid, 1'b0);

        // Fill, drop a 5th load, then drain in dispatch order.
        issue_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            load = 1'b1; inst_rs = mk(8'(k), 4'd0, 1'b1, 32'(k), 4'd0, 1'b1, 32'd0);
            tick();
        end
        load = 1'b0;
        #1 check_eq("fill_full", is_full, 1'b1);
        check_eq("fill_oldest", issue_inst.insn_tag, 8'd1);
        issue_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1 check_eq("drain_valid", issue_valid, 1'b1);
            check_eq("drain_order", issue_inst.insn_tag, 8'(k));
            tick();
            if (k == 1) check_eq("drain_not_full", is_full, 1'b0);
        end
        #1 check_eq("drain_empty", issue_valid, 1'b0);

        // Older entry waiting on CDB takes priority once woken.
        issue_ready = 1'b0;
        load = 1'b1; inst_rs = mk(8'h40, 4'd7, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0);
        tick();
        inst_rs = mk(8'h41, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2);
        tick(); load = 1'b0;
        #1 check_eq("age_young_first", issue_inst.insn_tag, 8'h41);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h77;
        tick(); cdb_valid = 1'b0;
        #1 check_eq("age_old_woken", issue_inst.insn_tag, 8'h40);
        check_eq("age_old_v1", issue_inst.value_src1, 32'h77);
        issue_ready = 1'b1;
        tick();
        #1 check_eq("age_after_issue", issue_inst.insn_tag, 8'h41);
        tick();
        #1 check_eq("age_empty", issue_valid, 1'b0);

        // Squash with a concurrent load.
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load = 1'b1; inst_rs = mk(8'(8'h50 + k), 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0);
            tick();
        end
        squash = 1'b1; inst_rs = mk(8'h60, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0);
        #1 check_eq("squash_no_issue", issue_valid, 1'b0);
        tick(); squash = 1'b0; load = 1'b0;
        #1 check_eq("squash_empty", issue_valid, 1'b0);
        check_eq("squash_not_full", is_full, 1'b0);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 2; k++) begin
            load = 1'b1; inst_rs = mk(8'(8'h70 + k), 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0);
            tick();
        end
        load = 1'b0;
        #1 check_eq("pre_reset_valid", issue_valid, 1'b1);
        #1 reset = 1'b0;
        #1 check_eq("areset_valid", issue_valid, 1'b0);
        check_eq("areset_inst", issue_inst, '0);
        check_eq("areset_full", is_full, 1'b0);
        tick();
        reset = 1'b1;
        load = 1'b1; inst_rs = mk(8'h80, 4'd0, 1'b1, 32'd11, 4'd0, 1'b1, 32'd12);
        tick(); load = 1'b0;
        #1 check_eq("post_reset_valid", issue_valid, 1'b1);
        check_eq("post_reset_tag", issue_inst.insn_tag, 8'h80);
        issue_ready = 1'b1;
        tick();
        #1 check_eq("post_reset_empty", issue_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The parameter list SHALL be: RS_SIZE, default 4, number of entries (power of two, 2..8).
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low; asserting it (low) clears state immediately.
- load  in  1  dispatch strobe; this RS's bit of RS_load.
- inst_rs  in  INST_RS  dispatched packet: fu, func, func3, tag_dest, tag_src1/2, ready_src1/2, value_src1/2, imm, pc, npc, insn_tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_TAG_LEN  broadcast ROB tag.
- cdb_value  in  XLEN  broadcast result.
- squash  in  1  branch-mispredict flush.
- issue_ready  in  1  FU accepts an instruction this cycle.
- issue_valid  out  1  issue_inst holds a fully ready entry.
- issue_inst  out  INST_RS  issued packet, ready_src1 = ready_src2 = 1.
- is_full  out  1  all entries valid; this RS's bit of RS_is_full.

Function
REQ-003 Each entry SHALL hold: valid, the INST_RS fields, and an age rank (0 = oldest).
REQ-004 is_full SHALL be combinational from registered valid bits: 1 iff all RS_SIZE entries are valid.
REQ-005 When load=1, squash=0 and is_full=0 at a posedge, the packet SHALL be written to the lowest-index invalid entry.
- Its rank SHALL be the count of valid entries that survive this edge.
REQ-006 When load=1 and is_full=1, the load SHALL be dropped with no state change.
- A same-edge issue SHALL NOT free a slot for that load.
REQ-007 Dispatch-time capture: if an incoming source has ready=0 and matches cdb_tag with cdb_valid=1 in the same cycle, the entry SHALL store ready=1 and value=cdb_value.
REQ-008 Wakeup: for every valid entry with a non-ready source whose tag equals cdb_tag while cdb_valid=1, that source SHALL become ready with value=cdb_value at the next posedge.
- Both sources and any number of entries MAY wake on one broadcast.
REQ-009 issue_valid SHALL be combinational: 1 iff squash=0 and some valid entry has both sources ready.
REQ-010 issue_inst SHALL be the ready entry with the lowest rank (oldest-first). When issue_valid=0, issue_inst SHALL be all zeros.
REQ-011 On a posedge with issue_valid=1 and issue_ready=1, the selected entry SHALL be invalidated, and every valid entry with a higher rank SHALL decrement its rank by 1.
REQ-012 Minimum latency SHALL be 1 cycle from dispatch to issue_valid.
- A source woken by the CDB SHALL be issuable on the cycle after the broadcast.
- There SHALL be no same-cycle CDB-to-issue bypass.
REQ-013 squash=1 at a posedge SHALL clear all valid bits. squash SHALL take priority over load, wakeup and issue in that cycle.
REQ-014 Issue and load SHALL both occur on the same edge when is_full=0.
- The load rank SHALL count surviving entries after the issue.
REQ-015 Entries that are valid and not selected SHALL hold all fields unchanged except wakeup and rank updates.
- issue_ready=0 SHALL leave state unchanged apart from load and wakeup.

Reset
REQ-016 While reset is low, all valid bits, ranks and stored fields SHALL be 0.
- Outputs SHALL be issue_valid=0, issue_inst=0, is_full=0.
REQ-017 Reset assertion mid-operation SHALL discard all entries asynchronously.
- The first load SHALL be accepted at the first posedge after reset rises.

Verification
REQ-018 Dispatch ALU op, both sources ready (value_src1=5, value_src2=7), issue_ready=1 -> issue_valid=1 next cycle with values 5/7; entry freed the following edge.
REQ-019 Dispatch with tag_src1=3 not ready; cdb_valid=1, cdb_tag=3, cdb_value=0x2A two cycles later -> issue_valid=1 on the cycle after the broadcast, value_src1=0x2A.
REQ-020 Dispatch tag_src2=6 not ready in the same cycle as CDB tag 6, value 9 -> entry stored ready; issue_valid=1 next cycle with value_src2=9.
REQ-021 Fill 4 entries with issue_ready=0 -> is_full=1; a 5th load is dropped. Raise issue_ready -> entries issue in dispatch order over 4 cycles; is_full=0 after the first.
REQ-022 Three valid entries, squash=1 for one cycle together with load=1 -> issue_valid=0 that cycle; next cycle all entries invalid and is_full=0.
REQ-023 Reset driven low mid-stream with two entries valid -> outputs go to 0 without a clock edge; after release, a new load issues normally.
